two_digit_stopwatch: RTL and testbench
======================================

# two_digit_stopwatch

Two-digit BCD up-counting stopwatch. It is the count-up counterpart of the two-digit countdown timer: each digit passes a carry to the next digit on the left, where the countdown passes a borrow. The block advances on an external one-cycle `tick` pulse from the shared prescaler. It stops at a programmable BCD limit, or free-runs 00..99 with wrap. Outputs are BCD nibbles for the existing seven-segment decode path.

## Interface
Parameters:
- `TICK_GATED`, default 1: when 1, `tick` is ignored unless the FSM is in RUN; when 0, `tick` also counts in IDLE (debug only).

Ports:
- `clock`  in  1  system clock; all state updates on its rising edge
- `reset`  in  1  asynchronous, active-low; clears all state
- `tick`  in  1  one-cycle increment request
- `start`  in  1  one-cycle pulse: IDLE→RUN
- `stop`  in  1  one-cycle pulse: RUN→IDLE (pause, count held)
- `clear`  in  1  synchronous clear of count and DONE
- `configure`  in  1  one-cycle pulse: capture limit (IDLE only)
- `limit_tens`  in  4  BCD tens digit of limit
- `limit_ones`  in  4  BCD ones digit of limit
- `tens_count`  out  4  BCD tens digit
- `ones_count`  out  4  BCD ones digit
- `carryout`  out  1  one-cycle pulse on reaching the limit or on the 99→00 wrap
- `done`  out  1  high while the FSM is in DONE

## Operation
- FSM states:
  - IDLE: count held; `configure` is accepted here only.
  - RUN: each sampled `tick` increments the count by one.
  - DONE: count frozen at the limit; `tick`, `start` and `stop` are ignored.
- Transitions:
  - IDLE→RUN on `start`.
  - RUN→IDLE on `stop`.
  - RUN→DONE when an increment makes the count equal the nonzero limit.
  - Any state→IDLE on `clear`, with the count set to 00.
- Priority: `clear` > `stop` > `start` > `tick`.
  - `start` and `stop` in the same cycle: `stop` wins, no state change from IDLE.
  - `tick` is ignored in any cycle where `clear` is asserted.
- Arithmetic:
  - Ones digit counts 0..9; on 9 plus tick it goes to 0 and asserts the internal carry.
  - The carry increments the tens digit in the same cycle.
  - Counts are always valid BCD.
- Limit:
  - Limit register 00 selects free-run: 99→00 wrap, `carryout` pulse, FSM stays in RUN.
  - A limit nibble >9 is clamped to 9 at capture.
  - `configure` outside IDLE is ignored; the limit register is unchanged.
- Reaching the limit: if the count already exceeds a newly captured limit, counting continues through the 99→00 wrap and stops when the count equals the limit.

## Timing
- All outputs are registered. Reset values: `tens_count`=0, `ones_count`=0, `carryout`=0, `done`=0, limit=00, state=IDLE.
- Latency: a `tick` sampled at edge N produces the new count visible after edge N; 1 cycle.
- `carryout` and `done` assert on the same edge as the count that reaches the limit. `carryout` lasts exactly 1 cycle. `done` holds until `clear` or `reset`.
- `start` sampled at edge N: a `tick` at edge N+1 counts. A `tick` coincident with `start` is not counted.
- `configure` takes effect for comparisons from the next edge.
- Reset asserted mid-count forces the reset values immediately, independent of `clock`. Counting resumes only after reset deasserts and a `start` pulse.

## Configuration
- Macro `STOPWATCH_LAP_EN`.
- Defined:
  - Adds input `lap` (1) and outputs `lap_tens` and `lap_ones` (4 each, reset 0).
  - A `lap` pulse in RUN or DONE copies the current count into the lap registers on the next edge; the count keeps running.
  - `clear` zeroes the lap registers.
- Undefined: these ports and registers do not exist; behaviour is otherwise identical.

## Structure
- Shared package `stopwatch_pkg` holds:
  - the FSM state enum (IDLE, RUN, DONE)
  - `DIGIT_W`=4
  - `BCD_MAX`=4'd9
- One sub-module, `bcd_digit_counter`, instantiated twice with carry chained from ones to tens.
  - Inputs: `clock`, `reset`, `clear`, `inc`.
  - Outputs: the 4-bit `digit` and a combinational `carry` = `inc` && `digit`==9.

## Test plan
- Reset, `start`, 12 ticks → count 12, `carryout`=0, `done`=0.
- `configure` limit 0/5 in IDLE, `start`, 5 ticks → count 05, `done`=1, one `carryout` pulse; a 6th tick leaves 05.
- Limit 00, count preloaded to 98 via ticks, 2 ticks → 99 then 00, single `carryout` pulse on the wrap, state stays RUN.
- `configure` limit A/C (invalid) → limit captured as 99; `configure` in RUN with 0/3 → ignored.
- `start`+`stop` same cycle in IDLE → stays IDLE. `clear`+`tick` at count 37 → 00 and IDLE. Async reset mid-RUN at 42 → all outputs 0 immediately.
- With `STOPWATCH_LAP_EN`: `lap` at count 23 → `lap_tens`/`lap_ones` = 2/3 while the count continues to 24.

Source files
------------

// File: rtl/stopwatch_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : stopwatch_pkg
//  Description : Shared FSM state encoding, digit width and BCD helpers for
//                the two-digit stopwatch. Optional lap feature: STOPWATCH_LAP_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
package stopwatch_pkg;

    localparam int DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Out-of-range limit nibbles saturate to the largest BCD digit.
    function automatic logic [DIGIT_W-1:0] clamp_bcd(input logic [DIGIT_W-1:0] d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/two_digit_stopwatch_if.sv
`default_nettype none
// ============================================================================
//  Interface   : two_digit_stopwatch_if
//  Description : Control, limit and BCD count signals of the stopwatch.
//                Lap ports exist only when STOPWATCH_LAP_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
interface two_digit_stopwatch_if;
    import stopwatch_pkg::*;

    logic               tick;
    logic               start;
    logic               stop;
    logic               clear;
    logic               configure;
    logic [DIGIT_W-1:0] limit_tens;
    logic [DIGIT_W-1:0] limit_ones;
    logic [DIGIT_W-1:0] tens_count;
    logic [DIGIT_W-1:0] ones_count;
    logic               carryout;
    logic               done;
`ifdef STOPWATCH_LAP_EN
    logic               lap;
    logic [DIGIT_W-1:0] lap_tens;
    logic [DIGIT_W-1:0] lap_ones;

    modport slave (
        input  tick, start, stop, clear, configure, limit_tens, limit_ones, lap,
        output tens_count, ones_count, carryout, done, lap_tens, lap_ones
    );
    modport master (
        output tick, start, stop, clear, configure, limit_tens, limit_ones, lap,
        input  tens_count, ones_count, carryout, done, lap_tens, lap_ones
    );
`else
    modport slave (
        input  tick, start, stop, clear, configure, limit_tens, limit_ones,
        output tens_count, ones_count, carryout, done
    );
    modport master (
        output tick, start, stop, clear, configure, limit_tens, limit_ones,
        input  tens_count, ones_count, carryout, done
    );
`endif

endinterface
`default_nettype wire

// File: rtl/bcd_digit_counter.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_digit_counter
//  Description : Single BCD digit 0..9 with synchronous clear and a
//                combinational carry that feeds the next digit on the left.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit_counter
    import stopwatch_pkg::*;
(
    input  wire logic               clock,
    input  wire logic               reset,
    input  wire logic               clear,
    input  wire logic               inc,
    output logic      [DIGIT_W-1:0] digit,
    output logic                    carry
);

    logic [DIGIT_W-1:0] r_digit;

    assign carry = inc && (r_digit == BCD_MAX);
    assign digit = r_digit;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_digit <= '0;
        end else if (clear) begin
            r_digit <= '0;
        end else if (inc) begin
            r_digit <= carry ? '0 : r_digit + DIGIT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/two_digit_stopwatch.sv
`default_nettype none
// ============================================================================
//  Module      : two_digit_stopwatch
//  Description : Two-digit BCD up-counting stopwatch with programmable stop
//                limit (00 = free-run with wrap). Optional lap capture is
//                enabled by defining STOPWATCH_LAP_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module two_digit_stopwatch
    import stopwatch_pkg::*;
#(
    parameter bit TICK_GATED = 1'b1
) (
    input  wire logic            clock,
    input  wire logic            reset,
    two_digit_stopwatch_if.slave bus
);

    state_t             r_state;
    logic [DIGIT_W-1:0] r_limit_tens;
    logic [DIGIT_W-1:0] r_limit_ones;
    logic               r_carryout;
    logic               r_done;

    logic [DIGIT_W-1:0] w_ones;
    logic [DIGIT_W-1:0] w_tens;
    logic [DIGIT_W-1:0] w_next_ones;
    logic [DIGIT_W-1:0] w_next_tens;
    logic               w_ones_carry;
    logic               w_tens_carry;
    logic               w_run_inc;
    logic               w_idle_inc;
    logic               w_inc;
    logic               w_limit_zero;
    logic               w_reach;

    // stop outranks tick, and a tick alongside start is not counted.
    assign w_run_inc = (r_state == RUN) && !bus.stop;

    generate
        if (TICK_GATED) begin : g_tick_gated
            assign w_idle_inc = 1'b0;
        end else begin : g_tick_free
            assign w_idle_inc = (r_state == IDLE) && !bus.stop && !bus.start;
        end
    endgenerate

    assign w_inc = bus.tick && !bus.clear && (w_run_inc || w_idle_inc);

    bcd_digit_counter u_ones (
        .clock (clock),
        .reset (reset),
        .clear (bus.clear),
        .inc   (w_inc),
        .digit (w_ones),
        .carry (w_ones_carry)
    );

    bcd_digit_counter u_tens (
        .clock (clock),
        .reset (reset),
        .clear (bus.clear),
        .inc   (w_ones_carry),
        .digit (w_tens),
        .carry (w_tens_carry)
    );

    // Count value after this cycle's increment, for the limit compare.
    assign w_next_ones  = w_ones_carry ? '0 : w_ones + DIGIT_W'(1);
    assign w_next_tens  = w_tens_carry ? '0 :
                          (w_ones_carry ? w_tens + DIGIT_W'(1) : w_tens);
    assign w_limit_zero = (r_limit_tens == '0) && (r_limit_ones == '0);
    assign w_reach      = !w_limit_zero &&
                          (w_next_tens == r_limit_tens) &&
                          (w_next_ones == r_limit_ones);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_limit_tens <= '0;
            r_limit_ones <= '0;
            r_carryout   <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_carryout <= w_inc && (w_reach || w_tens_carry);
            if (bus.clear) begin
                r_state <= IDLE;
                r_done  <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (bus.configure) begin
                            r_limit_tens <= clamp_bcd(bus.limit_tens);
                            r_limit_ones <= clamp_bcd(bus.limit_ones);
                        end
                        if (!bus.stop && bus.start) begin
                            r_state <= RUN;
                        end
                    end
                    RUN: begin
                        if (bus.stop) begin
                            r_state <= IDLE;
                        end else if (w_inc && w_reach) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end
                    end
                    DONE: begin
                        r_state <= DONE;
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.tens_count = w_tens;
    assign bus.ones_count = w_ones;
    assign bus.carryout   = r_carryout;
    assign bus.done       = r_done;

`ifdef STOPWATCH_LAP_EN
    logic [DIGIT_W-1:0] r_lap_tens;
    logic [DIGIT_W-1:0] r_lap_ones;

    // Lap snapshots the count held before this edge's increment.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_lap_tens <= '0;
            r_lap_ones <= '0;
        end else if (bus.clear) begin
            r_lap_tens <= '0;
            r_lap_ones <= '0;
        end else if (bus.lap && ((r_state == RUN) || (r_state == DONE))) begin
            r_lap_tens <= w_tens;
            r_lap_ones <= w_ones;
        end
    end

    assign bus.lap_tens = r_lap_tens;
    assign bus.lap_ones = r_lap_ones;
`endif

endmodule
`default_nettype wire

// File: tb/tb_two_digit_stopwatch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_two_digit_stopwatch
//  Description : Self-checking bench for two_digit_stopwatch using an integer
//                reference model; covers STOPWATCH_LAP_EN when defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_two_digit_stopwatch;

    localparam int c_idle = 0;
    localparam int c_run  = 1;
    localparam int c_done = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;
    bit   chk_en = 1'b0;

    int total = 0;
    int bad   = 0;

    int m_count = 0;
    int m_limit = 0;
    int m_state = c_idle;
    bit m_carry = 1'b0;
    int m_lap   = 0;

    two_digit_stopwatch_if bus ();

    two_digit_stopwatch dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    function automatic int clamp9(input logic [3:0] d);
        return (d > 4'd9) ? 9 : int'(d);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: whole-number count, limit and mode.
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_count = 0;
            m_limit = 0;
            m_state = c_idle;
            m_carry = 1'b0;
            m_lap   = 0;
        end else begin
            m_carry = 1'b0;
            if (bus.clear) begin
                m_count = 0;
                m_state = c_idle;
                m_lap   = 0;
            end else begin
`ifdef STOPWATCH_LAP_EN
                if (bus.lap && (m_state != c_idle)) m_lap = m_count;
`endif
                if (m_state == c_idle) begin
                    if (bus.configure)
                        m_limit = 10 * clamp9(bus.limit_tens) + clamp9(bus.limit_ones);
                    if (bus.start && !bus.stop) m_state = c_run;
                end else if (m_state == c_run) begin
                    if (bus.stop) begin
                        m_state = c_idle;
                    end else if (bus.tick) begin
                        m_count = (m_count + 1) % 100;
                        if (m_count == 0) m_carry = 1'b1;
                        if (m_limit != 0 && m_count == m_limit) begin
                            m_carry = 1'b1;
                            m_state = c_done;
                        end
                    end
                end
            end
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            chk("cyc_tens", int'(bus.tens_count), m_count / 10);
            chk("cyc_ones", int'(bus.ones_count), m_count % 10);
            chk("cyc_carryout", int'(bus.carryout), int'(m_carry));
            chk("cyc_done", int'(bus.done), (m_state == c_done) ? 1 : 0);
`ifdef STOPWATCH_LAP_EN
            chk("cyc_lap_tens", int'(bus.lap_tens), m_lap / 10);
            chk("cyc_lap_ones", int'(bus.lap_ones), m_lap % 10);
`endif
        end
    end

    task automatic cyc(input logic t, input logic st, input logic sp,
                       input logic cl, input logic cf);
        bus.tick      = t;
        bus.start     = st;
        bus.stop      = sp;
        bus.clear     = cl;
        bus.configure = cf;
        @(posedge clock);
        #1;
        bus.tick      = 1'b0;
        bus.start     = 1'b0;
        bus.stop      = 1'b0;
        bus.clear     = 1'b0;
        bus.configure = 1'b0;
    endtask

    task automatic ticks(input int n);
        repeat (n) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic config_limit(input logic [3:0] lt, input logic [3:0] lo);
        bus.limit_tens = lt;
        bus.limit_ones = lo;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    // Literal expectations on the DUT and the model together.
    task automatic expect_state(input string name, input int cnt, input int co, input int dn);
        chk({name, "_tens"}, int'(bus.tens_count), cnt / 10);
        chk({name, "_ones"}, int'(bus.ones_count), cnt % 10);
        chk({name, "_carryout"}, int'(bus.carryout), co);
        chk({name, "_done"}, int'(bus.done), dn);
        chk({name, "_model"}, m_count, cnt);
    endtask

    initial begin
        bus.tick = 1'b0;  bus.start = 1'b0; bus.stop = 1'b0;
        bus.clear = 1'b0; bus.configure = 1'b0;
        bus.limit_tens = 4'd0; bus.limit_ones = 4'd0;
`ifdef STOPWATCH_LAP_EN
        bus.lap = 1'b0;
`endif
        #1 reset = 1'b0;
        #2 chk_en = 1'b1;
        expect_state("reset", 0, 0, 0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;

        // Basic count, pause and resume.
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        ticks(12);
        expect_state("count12", 12, 0, 0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        ticks(3);
        expect_state("paused", 12, 0, 0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        ticks(1);
        expect_state("resumed", 13, 0, 0);

        // Limit 05 stops the count with a single carryout pulse.
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        config_limit(4'd0, 4'd5);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        ticks(4);
        expect_state("lim05_pre", 4, 0, 0);
        ticks(1);
        expect_state("lim05_hit", 5, 1, 1);
        ticks(1);
        expect_state("lim05_hold", 5, 0, 1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        ticks(1);
        expect_state("done_ignores_start", 5, 0, 1);

        // Free-run wrap with limit 00.
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        expect_state("clear_done", 0, 0, 0);
        config_limit(4'd0, 4'd0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        ticks(98);
        expect_state("free98", 98, 0, 0);
        ticks(1);
        expect_state("free99", 99, 0, 0);
        ticks(1);
        expect_state("wrap00", 0, 1, 0);
        ticks(1);
        expect_state("wrap01", 1, 0, 0);

        // Invalid limit nibbles clamp to 99; configure in RUN is ignored.
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        config_limit(4'hA, 4'hC);
        chk("clamp_model_limit", m_limit, 99);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        config_limit(4'd0, 4'd3);
        ticks(3);
        expect_state("cfg_in_run_ignored", 3, 0, 0);
        ticks(96);
        expect_state("lim99_hit", 99, 1, 1);

        // start+stop together in IDLE, and tick coincident with start.
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        ticks(2);
        expect_state("start_stop_idle", 0, 0, 0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_state("tick_with_start", 0, 0, 0);
        ticks(1);
        expect_state("tick_after_start", 1, 0, 0);

        // clear wins over tick at 37.
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        ticks(37);
        expect_state("count37", 37, 0, 0);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        expect_state("clear_tick", 0, 0, 0);
        ticks(2);
        expect_state("idle_after_clear", 0, 0, 0);

        // Asynchronous reset mid-run at 42.
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        ticks(42);
        expect_state("count42", 42, 0, 0);
        reset = 1'b0;
        #2;
        expect_state("async_reset", 0, 0, 0);
        @(posedge clock);
        #1 reset = 1'b1;
        ticks(3);
        expect_state("no_count_without_start", 0, 0, 0);

`ifdef STOPWATCH_LAP_EN
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        ticks(23);
        bus.lap = 1'b1;
        ticks(1);
        bus.lap = 1'b0;
        expect_state("lap_run", 24, 0, 0);
        chk("lap_tens_lit", int'(bus.lap_tens), 2);
        chk("lap_ones_lit", int'(bus.lap_ones), 3);
        ticks(1);
        expect_state("lap_continue", 25, 0, 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("lap_cleared", int'(bus.lap_tens) * 10 + int'(bus.lap_ones), 0);
`endif

        @(negedge clock);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
